muldiv_ctrl: RTL and testbench

//  Iterative multiply/divide sequencer for the MIPS pipeline's HI/LO unit. Executes MULT/MULTU/DIV/DIVU

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation/state encodings and decode helpers for the HI/LO multiply/divide unit.
// Revision: 1.0
`default_nettype none

package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    function automatic logic is_signed(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on the {acc, q} work pair -- shift-add multiply
// or restoring shift-subtract divide.  Revision: 1.0
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc} + (q[0] ? {1'b0, operand} : '0);
        rem      = {acc, q[WIDTH-1]};
        diff     = rem - {1'b0, operand};
        acc_next = '0;
        q_next   = '0;
        if (div_mode) begin
            // Partial remainder stays below the divisor, so rem fits in WIDTH+1 bits
            // and the top bit of diff is a clean borrow flag.
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = sum[WIDTH:1];
            q_next   = {sum[0], q[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall request.
// Optional MULDIV_MTHILO_EN adds mthiE/mtloE/mtD for direct HI/LO moves.  Revision: 1.0
`default_nettype none

module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             startE,
    input  op_t              opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             mfhiD,
    input  logic             mfloD,
    input  logic             muldivD,
`ifdef MULDIV_MTHILO_EN
    input  logic             mthiE,
    input  logic             mtloE,
    input  logic             mtD,
`endif
    output logic             busy,
    output logic             stall_md,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] operand;
    op_t              op_r;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;
    logic             d_reader;

    always_comb begin
        a_neg    = is_signed(opE) & srcaE[WIDTH-1];
        b_neg    = is_signed(opE) & srcbE[WIDTH-1];
        a_mag    = a_neg ? (~srcaE + 1'b1) : srcaE;
        b_mag    = b_neg ? (~srcbE + 1'b1) : srcbE;
        div_zero = is_div(opE) && (srcbE == '0);
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .div_mode(is_div(op_r)),
        .acc     (acc),
        .q       (q),
        .operand (operand),
        .acc_next(step_acc),
        .q_next  (step_q)
    );

    // Sign correction on magnitudes; the divide-by-zero path leaves both flags clear.
    always_comb begin
        prod_fix = neg_q ? (~{acc, q} + 1'b1) : {acc, q};
        quot_fix = neg_q ? (~q + 1'b1) : q;
        rem_fix  = neg_r ? (~acc + 1'b1) : acc;
        if (is_div(op_r)) begin
            hi_res = rem_fix;
            lo_res = quot_fix;
        end else begin
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (startE) begin
                    state_next = div_zero ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (count == LAST) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            acc     <= '0;
            q       <= '0;
            operand <= '0;
            op_r    <= OP_MULT;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (startE) begin
                        op_r  <= opE;
                        count <= '0;
                        if (div_zero) begin
                            acc     <= srcaE;
                            q       <= '1;
                            operand <= '0;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                        end else begin
                            acc     <= '0;
                            q       <= is_div(opE) ? a_mag : b_mag;
                            operand <= is_div(opE) ? b_mag : a_mag;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                        end
                    end
                end
                S_RUN: begin
                    acc   <= step_acc;
                    q     <= step_q;
                    count <= count + 1'b1;
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == S_FIX);
            if (state == S_FIX) begin
                hi <= hi_res;
                lo <= lo_res;
            end
`ifdef MULDIV_MTHILO_EN
            else if (state == S_IDLE) begin
                if (mthiE) hi <= srcaE;
                if (mtloE) lo <= srcaE;
            end
`endif
        end
    end

`ifdef MULDIV_MTHILO_EN
    assign d_reader = mfhiD | mfloD | muldivD | mtD;
`else
    assign d_reader = mfhiD | mfloD | muldivD;
`endif

    assign busy     = (state != S_IDLE);
    assign stall_md = busy & d_reader;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl with hand-computed results.
// Revision: 1.0
`default_nettype none

module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         startE;
    op_t          opE;
    logic [W-1:0] srcaE;
    logic [W-1:0] srcbE;
    logic         mfhiD;
    logic         mfloD;
    logic         muldivD;
`ifdef MULDIV_MTHILO_EN
    logic         mthiE;
    logic         mtloE;
    logic         mtD;
`endif
    logic         busy;
    logic         stall_md;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         done;

    int total = 0;
    int bad   = 0;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .startE  (startE),
        .opE     (opE),
        .srcaE   (srcaE),
        .srcbE   (srcbE),
        .mfhiD   (mfhiD),
        .mfloD   (mfloD),
        .muldivD (muldivD),
`ifdef MULDIV_MTHILO_EN
        .mthiE   (mthiE),
        .mtloE   (mtloE),
        .mtD     (mtD),
`endif
        .busy    (busy),
        .stall_md(stall_md),
        .hi      (hi),
        .lo      (lo),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Presents one operation for exactly one accepting edge; returns at the first busy cycle.
    task automatic issue(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        startE = 1'b1;
        opE    = o;
        srcaE  = a;
        srcbE  = b;
        @(negedge clk);
        startE = 1'b0;
        srcaE  = '0;
        srcbE  = '0;
    endtask

    task automatic run_to_idle(output int cyc, output int dones);
        cyc   = 0;
        dones = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, stall_md} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: busy/done/stall=%b want 000", {busy, done, stall_md});
        end
        total++;
        if ({hi, lo} !== 64'h0) begin
            bad++;
            $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", hi, lo);
        end
    endtask

    task automatic test_mult();
        int cyc, dn;
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        run_to_idle(cyc, dn);
        total++;
        if (cyc !== 33) begin bad++; $display("FAIL mult_latency: got %0d want 33", cyc); end
        total++;
        if (dn !== 1) begin bad++; $display("FAIL mult_done: pulses %0d want 1", dn); end
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            bad++; $display("FAIL mult_result: hi=%h lo=%h want ffffffff/ffffffeb", hi, lo);
        end
    endtask

    task automatic test_divu();
        int cyc, dn;
        issue(OP_DIVU, 32'd100, 32'd7);
        run_to_idle(cyc, dn);
        total++;
        if (cyc !== 33) begin bad++; $display("FAIL divu_latency: got %0d want 33", cyc); end
        total++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            bad++; $display("FAIL divu_result: hi=%h lo=%h want 2/e", hi, lo);
        end
    endtask

    task automatic test_div_signed();
        int cyc, dn;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_to_idle(cyc, dn);
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            bad++; $display("FAIL div_neg: hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
        end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_to_idle(cyc, dn);
        total++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            bad++; $display("FAIL div_overflow: hi=%h lo=%h want 0/80000000", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        int cyc, dn;
        issue(OP_DIV, 32'd5, 32'd0);
        run_to_idle(cyc, dn);
        total++;
        if (cyc !== 1) begin bad++; $display("FAIL div0_latency: got %0d want 1", cyc); end
        total++;
        if (dn !== 1) begin bad++; $display("FAIL div0_done: pulses %0d want 1", dn); end
        total++;
        if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin
            bad++; $display("FAIL div0_result: hi=%h lo=%h want 5/ffffffff", hi, lo);
        end
    endtask

    task automatic test_multu_max();
        int cyc, dn;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_to_idle(cyc, dn);
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            bad++; $display("FAIL multu_max: hi=%h lo=%h want fffffffe/1", hi, lo);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int wrong = 0;
        issue(OP_MULTU, 32'd6, 32'd7);
        @(negedge clk);
        mfloD = 1'b1;
        #1;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (stall_md !== 1'b1) wrong++;
            @(negedge clk);
            #1;
        end
        total++;
        if (wrong !== 0 || n !== 32) begin
            bad++; $display("FAIL stall_busy: low cycles %0d, stalled cycles %0d want 0/32", wrong, n);
        end
        total++;
        if (stall_md !== 1'b0) begin bad++; $display("FAIL stall_release: stall_md=%b want 0", stall_md); end
        total++;
        if (lo !== 32'd42 || hi !== 32'd0) begin
            bad++; $display("FAIL stall_result: hi=%h lo=%h want 0/2a", hi, lo);
        end
        mfloD = 1'b0;
        issue(OP_MULTU, 32'd2, 32'd3);
        mfhiD = 1'b1;
        #1;
        total++;
        if (stall_md !== 1'b1) begin bad++; $display("FAIL stall_mfhi: stall_md=%b want 1", stall_md); end
        mfhiD   = 1'b0;
        muldivD = 1'b1;
        #1;
        total++;
        if (stall_md !== 1'b1) begin bad++; $display("FAIL stall_muldiv: stall_md=%b want 1", stall_md); end
        muldivD = 1'b0;
        while (busy === 1'b1 && n < 400) begin n++; @(negedge clk); end
        mfloD = 1'b1;
        #1;
        total++;
        if (stall_md !== 1'b0) begin bad++; $display("FAIL stall_idle: stall_md=%b want 0", stall_md); end
        mfloD = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc, dn;
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        startE = 1'b1;
        opE    = OP_MULT;
        srcaE  = 32'd3;
        srcbE  = 32'd3;
        @(negedge clk);
        startE = 1'b0;
        srcaE  = '0;
        srcbE  = '0;
        run_to_idle(cyc, dn);
        total++;
        if (cyc !== 29 || {hi, lo} !== {32'd2, 32'd14}) begin
            bad++; $display("FAIL busy_start_ignored: remaining %0d hi=%h lo=%h want 29 2/e", cyc, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, dn;
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || {hi, lo} !== 64'h0) begin
            bad++; $display("FAIL midop_reset: busy=%b hi=%h lo=%h want 0 0/0", busy, hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        issue(OP_MULT, 32'd3, 32'd4);
        run_to_idle(cyc, dn);
        total++;
        if (cyc !== 33 || {hi, lo} !== {32'd0, 32'd12}) begin
            bad++; $display("FAIL after_reset_mult: cycles %0d hi=%h lo=%h want 33 0/c", cyc, hi, lo);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        startE  = 1'b0;
        opE     = OP_MULT;
        srcaE   = '0;
        srcbE   = '0;
        mfhiD   = 1'b0;
        mfloD   = 1'b0;
        muldivD = 1'b0;
`ifdef MULDIV_MTHILO_EN
        mthiE   = 1'b0;
        mtloE   = 1'b0;
        mtD     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_mult();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_multu_max();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
